sdram_arbiter: RTL and testbench

- Shares the single SDRAM controller (rd/we/ready handshake, 16-bit word bus) between two Wishbone-style masters.
- Port A is the CPU memory port; port B is the disk-DMA/auxiliary port.
- Sits between topboard16's SDRAM port and the sdram controller, in the clk_p domain.
- Provides round-robin arbitration, request sequencing, read-data capture and per-master single-cycle acknowledge.

---
 rtl/sdram_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller between a CPU port (A) and a DMA port (B).
// Defining SDRAM_ARB_WATCHDOG_EN adds a WAIT-state timeout that acks with 16'hFFFF and pulses err.
module sdram_arbiter #(
  parameter int unsigned AW      = 21,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk_p,
  input  logic          rst_n,
  input  logic          a_stb,
  input  logic          a_we,
  input  logic [1:0]    a_sel,
  input  logic [AW-1:0] a_adr,
  input  logic [15:0]   a_dat_i,
  output logic [15:0]   a_dat_o,
  output logic          a_ack,
  input  logic          b_stb,
  input  logic          b_we,
  input  logic [1:0]    b_sel,
  input  logic [AW-1:0] b_adr,
  input  logic [15:0]   b_dat_i,
  output logic [15:0]   b_dat_o,
  output logic          b_ack,
  output logic          sdr_rd,
  output logic          sdr_we,
  output logic [1:0]    sdr_wtbt,
  output logic [AW-1:0] sdr_addr,
  output logic [15:0]   sdr_din,
  input  logic [15:0]   sdr_dout,
  input  logic          sdr_ready,
  output logic          mem_ready,
  output logic          err
);

  typedef enum logic [2:0] {StInit, StIdle, StIssue, StWait, StAck} state_e;

  state_e        state_q, state_d;
  logic          gnt_q, gnt_d;    // 1: port B holds the grant
  logic          last_q, last_d;  // 1: port B was granted last
  logic          we_q, we_d;
  logic          skip_q, skip_d;
  logic          sdr_rd_q, sdr_rd_d, sdr_we_q, sdr_we_d;
  logic [1:0]    wtbt_q, wtbt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   din_q, din_d, a_dat_q, a_dat_d, b_dat_q, b_dat_d;
  logic          a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic          mem_ready_q, mem_ready_d;
  logic          pick_b, done, expired;
  logic [15:0]   rdata;

`ifdef SDRAM_ARB_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);
  logic [WdW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    we_d        = we_q;
    skip_d      = skip_q;
    sdr_rd_d    = 1'b0;
    sdr_we_d    = 1'b0;
    wtbt_d      = wtbt_q;
    addr_d      = addr_q;
    din_d       = din_q;
    a_dat_d     = a_dat_q;
    b_dat_d     = b_dat_q;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    mem_ready_d = mem_ready_q | sdr_ready;
    pick_b      = b_stb & (~a_stb | ~last_q);
    done        = 1'b0;
    expired     = 1'b0;
    rdata       = sdr_dout;
`ifdef SDRAM_ARB_WATCHDOG_EN
    wd_d        = wd_q;
    err_d       = 1'b0;
`endif
    unique case (state_q)
      StInit: if (sdr_ready) state_d = StIdle;
      StIdle: begin
        if ((a_stb | b_stb) & sdr_ready) begin
          gnt_d    = pick_b;
          we_d     = pick_b ? b_we : a_we;
          addr_d   = pick_b ? b_adr : a_adr;
          din_d    = pick_b ? b_dat_i : a_dat_i;
          wtbt_d   = we_d ? (pick_b ? b_sel : a_sel) : 2'b11;
          sdr_rd_d = ~we_d;
          sdr_we_d = we_d;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        skip_d  = 1'b1;
        state_d = StWait;
`ifdef SDRAM_ARB_WATCHDOG_EN
        wd_d    = '0;
`endif
      end
      StWait: begin
        // The controller's ready may still be stale in the first WAIT cycle.
        if (skip_q) skip_d = 1'b0;
        else        done   = sdr_ready;
`ifdef SDRAM_ARB_WATCHDOG_EN
        if (!done) begin
          if (wd_q == WdW'(TIMEOUT - 1)) expired = 1'b1;
          else                           wd_d    = wd_q + WdW'(1);
        end
        err_d = expired;
`endif
        if (done | expired) begin
          state_d = StAck;
          a_ack_d = ~gnt_q;
          b_ack_d = gnt_q;
          rdata   = expired ? 16'hFFFF : sdr_dout;
          if (!we_q) begin
            if (gnt_q) b_dat_d = rdata;
            else       a_dat_d = rdata;
          end
        end
      end
      StAck: begin
        last_d  = gnt_q;
        state_d = StIdle;
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StInit;
      gnt_q       <= 1'b0;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      skip_q      <= 1'b0;
      sdr_rd_q    <= 1'b0;
      sdr_we_q    <= 1'b0;
      wtbt_q      <= 2'b00;
      addr_q      <= '0;
      din_q       <= '0;
      a_dat_q     <= '0;
      b_dat_q     <= '0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      mem_ready_q <= 1'b0;
`ifdef SDRAM_ARB_WATCHDOG_EN
      wd_q        <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      we_q        <= we_d;
      skip_q      <= skip_d;
      sdr_rd_q    <= sdr_rd_d;
      sdr_we_q    <= sdr_we_d;
      wtbt_q      <= wtbt_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      a_dat_q     <= a_dat_d;
      b_dat_q     <= b_dat_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      mem_ready_q <= mem_ready_d;
`ifdef SDRAM_ARB_WATCHDOG_EN
      wd_q        <= wd_d;
      err_q       <= err_d;
`endif
    end
  end

  assign sdr_rd    = sdr_rd_q;
  assign sdr_we    = sdr_we_q;
  assign sdr_wtbt  = wtbt_q;
  assign sdr_addr  = addr_q;
  assign sdr_din   = din_q;
  assign a_dat_o   = a_dat_q;
  assign b_dat_o   = b_dat_q;
  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign mem_ready = mem_ready_q;
`ifdef SDRAM_ARB_WATCHDOG_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: expected issues/acks are queued by the stimulus thread
// and popped by monitors; a small controller model returns a stale ready in the first WAIT cycle.
module tb_sdram_arbiter;
  localparam int unsigned AW = 21;

  logic          clk_p, rst_n;
  logic          a_stb, a_we, b_stb, b_we;
  logic [1:0]    a_sel, b_sel, sdr_wtbt;
  logic [AW-1:0] a_adr, b_adr, sdr_addr;
  logic [15:0]   a_dat_i, a_dat_o, b_dat_i, b_dat_o, sdr_din, sdr_dout;
  logic          a_ack, b_ack, sdr_rd, sdr_we, sdr_ready, mem_ready, err;

  sdram_arbiter #(.AW(AW), .TIMEOUT(16)) dut (
    .clk_p(clk_p), .rst_n(rst_n),
    .a_stb(a_stb), .a_we(a_we), .a_sel(a_sel), .a_adr(a_adr), .a_dat_i(a_dat_i),
    .a_dat_o(a_dat_o), .a_ack(a_ack),
    .b_stb(b_stb), .b_we(b_we), .b_sel(b_sel), .b_adr(b_adr), .b_dat_i(b_dat_i),
    .b_dat_o(b_dat_o), .b_ack(b_ack),
    .sdr_rd(sdr_rd), .sdr_we(sdr_we), .sdr_wtbt(sdr_wtbt), .sdr_addr(sdr_addr),
    .sdr_din(sdr_din), .sdr_dout(sdr_dout), .sdr_ready(sdr_ready),
    .mem_ready(mem_ready), .err(err)
  );

  typedef struct {
    logic rd; logic we; logic [AW-1:0] addr; logic [1:0] wtbt; logic [15:0] din;
  } iss_t;
  typedef struct {
    logic port_b; logic [15:0] a_dat; logic [15:0] b_dat; logic err;
  } ack_t;

  iss_t iss_q[$];
  ack_t ack_q[$];
  int n_chk = 0, n_fail = 0;
  int iss_cnt = 0, ack_cnt = 0, cyc = 0, iss_cyc = 0, ack_cyc = 0;
  logic ctl_en, ctl_stuck;
  int ctl_lat;
  logic [15:0] ctl_data;

  initial begin
    clk_p = 1'b0;
    forever #5 clk_p = ~clk_p;
  end

  always @(posedge clk_p) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cyc_n(input int n);
    repeat (n) begin @(negedge clk_p); #1; end
  endtask

  task automatic push_iss(input logic rd, input logic we, input logic [AW-1:0] addr,
                          input logic [1:0] wtbt, input logic [15:0] din);
    iss_t it;
    it.rd = rd; it.we = we; it.addr = addr; it.wtbt = wtbt; it.din = din;
    iss_q.push_back(it);
  endtask

  task automatic push_ack(input logic pb, input logic [15:0] ad, input logic [15:0] bd,
                          input logic e);
    ack_t it;
    it.port_b = pb; it.a_dat = ad; it.b_dat = bd; it.err = e;
    ack_q.push_back(it);
  endtask

  task automatic wait_ack(input int target, input int budget);
    int n = 0;
    while (ack_cnt < target && n < budget) begin cyc_n(1); n++; end
    chk("ack_wait", 32'(ack_cnt >= target), 32'd1);
  endtask

  task automatic wait_iss(input int target, input int budget);
    int n = 0;
    while (iss_cnt < target && n < budget) begin cyc_n(1); n++; end
    chk("issue_wait", 32'(iss_cnt >= target), 32'd1);
  endtask

  // Controller model: ready stays high (stale) through the first WAIT cycle, then drops.
  initial begin
    int cst, busy;
    cst = 0; busy = 0;
    sdr_ready = 1'b0;
    sdr_dout  = 16'hDEAD;
    forever begin
      @(negedge clk_p);
      if (!ctl_en) begin
        sdr_ready = 1'b0; cst = 0;
      end else begin
        case (cst)
          0: begin
            if (sdr_rd || sdr_we) cst = 1;
            else begin sdr_ready = 1'b1; sdr_dout = 16'hDEAD; end
          end
          1: begin cst = 2; busy = ctl_lat; end
          2: begin
            sdr_ready = 1'b0;
            if (busy > 0) busy--;
            if (busy == 0 && !ctl_stuck) begin
              sdr_ready = 1'b1; sdr_dout = ctl_data; cst = 3;
            end
          end
          default: cst = 0;
        endcase
      end
    end
  end

  // Issue monitor
  initial begin
    iss_t it;
    forever begin
      @(negedge clk_p);
      if (rst_n && (sdr_rd || sdr_we)) begin
        iss_cnt++;
        iss_cyc = cyc;
        if (iss_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_issue: got rd=%b we=%b addr=%0h, expected none", sdr_rd,
                   sdr_we, sdr_addr);
        end else begin
          it = iss_q.pop_front();
          chk("iss_rd", 32'(sdr_rd), 32'(it.rd));
          chk("iss_we", 32'(sdr_we), 32'(it.we));
          chk("iss_addr", 32'(sdr_addr), 32'(it.addr));
          chk("iss_wtbt", 32'(sdr_wtbt), 32'(it.wtbt));
          chk("iss_din", 32'(sdr_din), 32'(it.din));
        end
      end
    end
  end

  // Ack monitor
  initial begin
    ack_t it;
    forever begin
      @(negedge clk_p);
      if (rst_n && err && !(a_ack || b_ack)) begin
        n_chk++; n_fail++;
        $display("FAIL err_without_ack: got err=1, expected 0");
      end
      if (rst_n && (a_ack || b_ack)) begin
        ack_cnt++;
        ack_cyc = cyc;
        chk("ack_both", 32'(a_ack && b_ack), 32'd0);
        if (ack_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_ack: got a_ack=%b b_ack=%b, expected none", a_ack, b_ack);
        end else begin
          it = ack_q.pop_front();
          chk("ack_port_b", 32'(b_ack), 32'(it.port_b));
          chk("ack_a_dat", 32'(a_dat_o), 32'(it.a_dat));
          chk("ack_b_dat", 32'(b_dat_o), 32'(it.b_dat));
          chk("ack_err", 32'(err), 32'(it.err));
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sdr_rd"}, 32'(sdr_rd), 32'd0);
    chk({tag, "_sdr_we"}, 32'(sdr_we), 32'd0);
    chk({tag, "_a_ack"}, 32'(a_ack), 32'd0);
    chk({tag, "_b_ack"}, 32'(b_ack), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_mem_ready"}, 32'(mem_ready), 32'd0);
    chk({tag, "_a_dat_o"}, 32'(a_dat_o), 32'd0);
    chk({tag, "_b_dat_o"}, 32'(b_dat_o), 32'd0);
    chk({tag, "_sdr_addr"}, 32'(sdr_addr), 32'd0);
    chk({tag, "_sdr_din"}, 32'(sdr_din), 32'd0);
    chk({tag, "_sdr_wtbt"}, 32'(sdr_wtbt), 32'd0);
  endtask

  initial begin
    int tgt, ic;
    rst_n = 1'b0; ctl_en = 1'b0; ctl_stuck = 1'b0; ctl_lat = 3; ctl_data = 16'h0;
    a_stb = 1'b0; a_we = 1'b0; a_sel = 2'b11; a_adr = '0; a_dat_i = 16'h0;
    b_stb = 1'b0; b_we = 1'b0; b_sel = 2'b11; b_adr = '0; b_dat_i = 16'h0;
    cyc_n(3);
    chk_reset_outputs("rst");

    // Reset/init: no issue while the controller is not ready
    rst_n = 1'b1;
    a_adr = 21'h000050; a_stb = 1'b1;
    cyc_n(20);
    chk("init_no_issue", 32'(iss_cnt), 32'd0);
    chk("init_mem_ready", 32'(mem_ready), 32'd0);
    push_iss(1'b1, 1'b0, 21'h000050, 2'b11, 16'h0000);
    push_ack(1'b0, 16'h0F0F, 16'h0000, 1'b0);
    ctl_data = 16'h0F0F; ctl_en = 1'b1;
    cyc_n(2);
    chk("mem_ready_set", 32'(mem_ready), 32'd1);
    wait_ack(1, 60);
    a_stb = 1'b0;
    cyc_n(2);

    // Single read on A
    a_adr = 21'h000100; ctl_data = 16'h1234;
    push_iss(1'b1, 1'b0, 21'h000100, 2'b11, 16'h0000);
    push_ack(1'b0, 16'h1234, 16'h0000, 1'b0);
    a_stb = 1'b1;
    wait_ack(2, 60);
    a_stb = 1'b0;
    cyc_n(2);

    // Byte write on B
    b_we = 1'b1; b_sel = 2'b10; b_adr = 21'h1F0000; b_dat_i = 16'hAB00;
    push_iss(1'b0, 1'b1, 21'h1F0000, 2'b10, 16'hAB00);
    push_ack(1'b1, 16'h1234, 16'h0000, 1'b0);
    b_stb = 1'b1;
    wait_ack(3, 60);
    b_stb = 1'b0;
    cyc_n(2);

    // Contention: A writes, B reads, strict alternation starting with A
    a_we = 1'b1; a_sel = 2'b11; a_adr = 21'h000300; a_dat_i = 16'h1111;
    b_we = 1'b0; b_sel = 2'b01; b_adr = 21'h000400; b_dat_i = 16'h2222;
    ctl_data = 16'hC0DE;
    for (int i = 0; i < 3; i++) begin
      push_iss(1'b0, 1'b1, 21'h000300, 2'b11, 16'h1111);
      push_ack(1'b0, 16'h1234, (i == 0) ? 16'h0000 : 16'hC0DE, 1'b0);
      push_iss(1'b1, 1'b0, 21'h000400, 2'b11, 16'h2222);
      push_ack(1'b1, 16'h1234, 16'hC0DE, 1'b0);
    end
    a_stb = 1'b1; b_stb = 1'b1;
    wait_ack(9, 300);
    a_stb = 1'b0; b_stb = 1'b0;
    cyc_n(2);

    // A alone holding stb is regranted back-to-back
    a_we = 1'b1; a_sel = 2'b01; a_adr = 21'h0ABCDE; a_dat_i = 16'h00EF;
    for (int i = 0; i < 2; i++) begin
      push_iss(1'b0, 1'b1, 21'h0ABCDE, 2'b01, 16'h00EF);
      push_ack(1'b0, 16'h1234, 16'hC0DE, 1'b0);
    end
    a_stb = 1'b1;
    wait_ack(11, 120);
    a_stb = 1'b0;
    cyc_n(2);

    // Reset while in WAIT
    a_we = 1'b0; a_sel = 2'b11; a_adr = 21'h000777; a_dat_i = 16'h0000;
    ctl_stuck = 1'b1;
    push_iss(1'b1, 1'b0, 21'h000777, 2'b11, 16'h0000);
    ic = iss_cnt;
    a_stb = 1'b1;
    wait_iss(ic + 1, 40);
    cyc_n(3);
    rst_n = 1'b0; ctl_en = 1'b0; ctl_stuck = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    cyc_n(2);
    rst_n = 1'b1;
    cyc_n(10);
    chk("reinit_no_issue", 32'(iss_cnt), 32'(ic + 1));
    chk("reinit_mem_ready", 32'(mem_ready), 32'd0);
    ctl_data = 16'h7777;
    push_iss(1'b1, 1'b0, 21'h000777, 2'b11, 16'h0000);
    push_ack(1'b0, 16'h7777, 16'h0000, 1'b0);
    ctl_en = 1'b1;
    wait_ack(12, 60);
    a_stb = 1'b0;
    cyc_n(2);

    // Controller lockup
    a_adr = 21'h001234; ctl_stuck = 1'b1;
    push_iss(1'b1, 1'b0, 21'h001234, 2'b11, 16'h0000);
    tgt = ack_cnt;
`ifdef SDRAM_ARB_WATCHDOG_EN
    push_ack(1'b0, 16'hFFFF, 16'h0000, 1'b1);
    a_stb = 1'b1;
    wait_ack(tgt + 1, 80);
    chk("wd_latency", 32'(ack_cyc - iss_cyc), 32'd17);
`else
    a_stb = 1'b1;
    cyc_n(1000);
    chk("no_wd_ack", 32'(ack_cnt), 32'(tgt));
`endif
    a_stb = 1'b0;
    rst_n = 1'b0; ctl_en = 1'b0;
    cyc_n(2);

    chk("iss_q_empty", 32'(iss_q.size()), 32'd0);
    chk("ack_q_empty", 32'(ack_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
